// File: rtl/text_char_renderer_16x16.sv
`default_nettype none
// ============================================================================
//  Module   : text_char_renderer_16x16
//  Function : Overlays a 16x16-cell text box (8x16 px glyphs) on a VGA pixel
//             stream. Drives the text-ROM index and font-ROM line address,
//             picks the glyph bit from the returned font row and replaces the
//             pixel colour where the bit is set. All stream signals leave
//             exactly 4 clocks after they enter.
//  Options  : define TEXT_BG_EN for an opaque box (in-box background pixels
//             become BG_COLOR); undefined gives transparent text.
//  Revision : 1.0 - initial release
// ============================================================================
module text_char_renderer_16x16 #(
  parameter logic [10:0] XPOS     = 11'd0,
  parameter logic [10:0] YPOS     = 11'd0,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [10:0] char_line_addr,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Box geometry: 16 columns of 8 px, 16 rows of 16 px.
  localparam logic [11:0] BOX_W  = 12'd128;
  localparam logic [11:0] BOX_H  = 12'd256;
  localparam int          SIDE_W = 38;

  // Box limits are formed at 12 bits so a box touching the top of the
  // 11-bit coordinate range does not wrap around to zero.
  localparam logic [11:0] X_LO = {1'b0, XPOS};
  localparam logic [11:0] X_HI = {1'b0, XPOS} + BOX_W;
  localparam logic [11:0] Y_LO = {1'b0, YPOS};
  localparam logic [11:0] Y_HI = {1'b0, YPOS} + BOX_H;

  // --------------------------------------------------------------------------
  // Stage-0 combinational decode
  // --------------------------------------------------------------------------
  logic              in_box_c;
  logic [6:0]        rel_x_c;
  logic [7:0]        rel_y_c;
  logic [SIDE_W-1:0] side_in;

  // Only the low offset bits are ever needed, so the subtraction is done at
  // that width; modulo arithmetic gives the same low bits as the full one.
  assign rel_x_c = hcount_in[6:0] - XPOS[6:0];
  assign rel_y_c = vcount_in[7:0] - YPOS[7:0];

  // Unsigned range compares; the sign of the offset is never consulted.
  assign in_box_c = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
                    ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);

  // Side-band stream bundle carried through the pipeline untouched.
  assign side_in = {hcount_in, vcount_in, hsync_in, vsync_in,
                    hblnk_in, vblnk_in, rgb_in};

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic [3:0]        rel_y_s1;
  logic [2:0]        rel_x_s1;
  logic              in_box_s1;
  logic [SIDE_W-1:0] side_s1;

  logic [2:0]        rel_x_s2;
  logic              in_box_s2;
  logic [SIDE_W-1:0] side_s2;

  logic [2:0]        rel_x_s3;
  logic              in_box_s3;
  logic [SIDE_W-1:0] side_s3;

  // S1: cell index for the text ROM plus the glyph coordinates inside the cell.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char_xy   <= 8'h00;
      rel_y_s1  <= 4'd0;
      rel_x_s1  <= 3'd0;
      in_box_s1 <= 1'b0;
      side_s1   <= '0;
    end else begin
      char_xy   <= in_box_c ? {rel_y_c[7:4], rel_x_c[6:3]} : 8'h00;
      rel_y_s1  <= rel_y_c[3:0];
      rel_x_s1  <= rel_x_c[2:0];
      in_box_s1 <= in_box_c;
      side_s1   <= side_in;
    end
  end

  // S2: text ROM answers combinationally; form the font-ROM line address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char_line_addr <= 11'h000;
      rel_x_s2       <= 3'd0;
      in_box_s2      <= 1'b0;
      side_s2        <= '0;
    end else begin
      char_line_addr <= {char_code, rel_y_s1};
      rel_x_s2       <= rel_x_s1;
      in_box_s2      <= in_box_s1;
      side_s2        <= side_s1;
    end
  end

  // S3: the font ROM registers its row on this edge; keep the rest aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rel_x_s3  <= 3'd0;
      in_box_s3 <= 1'b0;
      side_s3   <= '0;
    end else begin
      rel_x_s3  <= rel_x_s2;
      in_box_s3 <= in_box_s2;
      side_s3   <= side_s2;
    end
  end

  // --------------------------------------------------------------------------
  // Pixel colour selection (feeds the output registers)
  // --------------------------------------------------------------------------
  logic [10:0] hcount_s3;
  logic [10:0] vcount_s3;
  logic        hsync_s3;
  logic        vsync_s3;
  logic        hblnk_s3;
  logic        vblnk_s3;
  logic [11:0] rgb_s3;
  logic        glyph_bit;
  logic [11:0] fill_rgb;
  logic [11:0] pix_rgb;

  assign {hcount_s3, vcount_s3, hsync_s3, vsync_s3,
          hblnk_s3, vblnk_s3, rgb_s3} = side_s3;

  // Font rows are stored MSB-first, so column 0 of the cell is bit 7.
  assign glyph_bit = char_pixels[3'd7 - rel_x_s3];

`ifdef TEXT_BG_EN
  // Opaque box: unlit glyph pixels take the box background colour.
  assign fill_rgb = BG_COLOR;
`else
  // Transparent text: unlit glyph pixels show the incoming background.
  logic [11:0] unused_bg_color;
  assign unused_bg_color = BG_COLOR;
  assign fill_rgb        = rgb_s3;
`endif

  // Blanking has priority, then lit glyph pixels, then the in-box fill.
  always_comb begin
    pix_rgb = rgb_s3;
    if (hblnk_s3 || vblnk_s3) begin
      pix_rgb = 12'h000;
    end else if (in_box_s3) begin
      pix_rgb = glyph_bit ? FG_COLOR : fill_rgb;
    end
  end

  // S4: register the complete output stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_out <= 11'd0;
      vcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'h000;
    end else begin
      hcount_out <= hcount_s3;
      vcount_out <= vcount_s3;
      hsync_out  <= hsync_s3;
      vsync_out  <= vsync_s3;
      hblnk_out  <= hblnk_s3;
      vblnk_out  <= vblnk_s3;
      rgb_out    <= pix_rgb;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_text_char_renderer_16x16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_text_char_renderer_16x16
//  Function : Directed self-checking bench for text_char_renderer_16x16 with
//             a combinational text ROM and a registered font ROM model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_text_char_renderer_16x16;

  localparam logic [10:0] XPOS     = 11'd100;
  localparam logic [10:0] YPOS     = 11'd50;
  localparam logic [11:0] FG_COLOR = 12'hFFF;
  localparam logic [11:0] BG_COLOR = 12'h5A5;

  logic        clk;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [10:0] char_line_addr;
  logic [7:0]  char_pixels;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int errors = 0;
  int checks = 0;

  logic [6:0] text_mem [256];
  logic [7:0] font_mem [2048];

  text_char_renderer_16x16 #(
    .XPOS(XPOS), .YPOS(YPOS), .FG_COLOR(FG_COLOR), .BG_COLOR(BG_COLOR)
  ) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .char_xy(char_xy), .char_code(char_code),
    .char_line_addr(char_line_addr), .char_pixels(char_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Text ROM answers in the same cycle; font ROM registers its row.
  assign char_code = text_mem[char_xy];
  always @(posedge clk) char_pixels <= font_mem[char_line_addr];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    hcount_in = 11'd0;  vcount_in = 11'd0;
    hsync_in  = 1'b0;   vsync_in  = 1'b0;
    hblnk_in  = 1'b0;   vblnk_in  = 1'b0;
    rgb_in    = 12'h777;
  endtask

  // Present one pixel for one clock, then idle filler, and check each stage
  // at its documented latency.
  task automatic run_pixel(input string tag,
                           input logic [10:0] h, input logic [10:0] v,
                           input logic hs, input logic vs,
                           input logic hb, input logic vb,
                           input logic [11:0] rgb,
                           input logic [7:0] exp_xy,
                           input logic [10:0] exp_addr,
                           input logic [11:0] exp_rgb);
    @(negedge clk);
    hcount_in = h;  vcount_in = v;
    hsync_in  = hs; vsync_in  = vs;
    hblnk_in  = hb; vblnk_in  = vb;
    rgb_in    = rgb;
    @(posedge clk); #1;
    check_val({tag, ".xy"}, {24'd0, char_xy}, {24'd0, exp_xy});
    drive_idle();
    @(posedge clk); #1;
    check_val({tag, ".addr"}, {21'd0, char_line_addr}, {21'd0, exp_addr});
    @(posedge clk); #1;
    check_val({tag, ".rgb_early"}, {31'd0, (rgb_out == exp_rgb && hcount_out == h && h != 11'd0)}, 32'd0);
    @(posedge clk); #1;
    check_val({tag, ".rgb"},    {20'd0, rgb_out},    {20'd0, exp_rgb});
    check_val({tag, ".hcount"}, {21'd0, hcount_out}, {21'd0, h});
    check_val({tag, ".vcount"}, {21'd0, vcount_out}, {21'd0, v});
    check_val({tag, ".sync"},  {28'd0, hsync_out, vsync_out, hblnk_out, vblnk_out},
                               {28'd0, hs, vs, hb, vb});
  endtask

  initial begin
    logic [11:0] exp_fill;
    for (int i = 0; i < 256; i++)  text_mem[i] = 7'h00;
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
    text_mem[8'h00] = 7'h42;
    text_mem[8'h23] = 7'h63;
    text_mem[8'h0F] = 7'h11;
    text_mem[8'hF0] = 7'h7F;
    font_mem[11'h637] = 8'b0000_0100;
    font_mem[11'h110] = 8'b0000_0001;
    font_mem[11'h7FF] = 8'b1000_0000;

`ifdef TEXT_BG_EN
    exp_fill = BG_COLOR;
`else
    exp_fill = 12'h123;
`endif

    // Reset held with random stream inputs: everything stays zero.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hcount_in = 11'($urandom); vcount_in = 11'($urandom);
      hsync_in  = 1'($urandom);  vsync_in  = 1'($urandom);
      hblnk_in  = 1'($urandom);  vblnk_in  = 1'($urandom);
      rgb_in    = 12'($urandom);
    end
    @(negedge clk);
    check_val("rst.xy",   {24'd0, char_xy}, 32'd0);
    check_val("rst.addr", {21'd0, char_line_addr}, 32'd0);
    check_val("rst.out",  {rgb_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 32'd0);
    check_val("rst.cnt",  {hcount_out, vcount_out}, 32'd0);
    drive_idle();
    rst = 1'b1;

    // Top-left cell, glyph row blank: transparent/opaque fill.
    run_pixel("origin", 11'd100, 11'd50, 1'b1, 1'b0, 1'b0, 1'b0, 12'h123,
              8'h00, 11'h420, exp_fill);
    // Cell (row 2, col 3), glyph row 7, bit 5 lit.
    run_pixel("glyph", 11'd129, 11'd89, 1'b0, 1'b1, 1'b0, 1'b0, 12'h456,
              8'h23, 11'h637, FG_COLOR);
    // Just left and just right of the box.
    run_pixel("left", 11'd99, 11'd60, 1'b1, 1'b1, 1'b0, 1'b0, 12'hABC,
              8'h00, 11'h42A, 12'hABC);
    run_pixel("right", 11'd228, 11'd60, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC,
              8'h00, 11'h42A, 12'hABC);
    // Last column and last row inside the box, both lit.
    run_pixel("lastcol", 11'd227, 11'd50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321,
              8'h0F, 11'h110, FG_COLOR);
    run_pixel("lastrow", 11'd100, 11'd305, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321,
              8'hF0, 11'h7FF, FG_COLOR);
    // First row below the box.
    run_pixel("below", 11'd100, 11'd306, 1'b0, 1'b0, 1'b0, 1'b0, 12'h246,
              8'h00, 11'h420, 12'h246);
    // Lit glyph pixel under horizontal and vertical blanking.
    run_pixel("hblank", 11'd129, 11'd89, 1'b0, 1'b0, 1'b1, 1'b0, 12'h456,
              8'h23, 11'h637, 12'h000);
    run_pixel("vblank", 11'd129, 11'd89, 1'b0, 1'b0, 1'b0, 1'b1, 12'h456,
              8'h23, 11'h637, 12'h000);

    // Asynchronous reset in the middle of a full pipeline.
    @(negedge clk);
    hcount_in = 11'd129; vcount_in = 11'd89; rgb_in = 12'h9AB; hsync_in = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check_val("mid.pre", {20'd0, rgb_out}, {20'd0, FG_COLOR});
    rst = 1'b0;
    #1;
    check_val("mid.xy",  {24'd0, char_xy}, 32'd0);
    check_val("mid.out", {rgb_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 32'd0);
    check_val("mid.cnt", {hcount_out, vcount_out}, 32'd0);
    check_val("mid.addr", {21'd0, char_line_addr}, 32'd0);
    drive_idle();
    @(negedge clk);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/text_char_renderer_16x16.md
# text_char_renderer_16x16

Pixel-pipeline renderer that reads a 16×16 character text ROM and overlays the characters on the VGA stream. It sits between the timing/background stage and the next drawing stage. From each pixel position it computes the character cell index (`char_xy`), takes the returned `char_code` and forms a font-ROM line address. It then picks the glyph bit from the font row and replaces the pixel colour where the bit is set. All VGA timing signals pass through with the same fixed latency as the pixel data.

## Interface
- `XPOS`, 11'd0: left edge of the text box, in pixels.
- `YPOS`, 11'd0: top edge of the text box, in pixels.
- `FG_COLOR`, 12'hFFF: RGB444 colour of set glyph pixels.
- `BG_COLOR`, 12'h000: box background colour (used only with `TEXT_BG_EN`).

Ports. The clock is `clk`, single clock domain. Reset is `rst`, asynchronous and active-low (asserted at 0).
- `clk`  in  1  pixel clock
- `rst`  in  1  async active-low reset
- `hcount_in`, `vcount_in`  in  11 each  pixel position
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`  in  1 each  timing/blanking
- `rgb_in`  in  12  background pixel
- `char_xy`  out  8  text-ROM index {row[3:0], col[3:0]}
- `char_code`  in  7  ASCII code from the text ROM (combinational ROM, valid in the same cycle)
- `char_line_addr`  out  11  font-ROM address {char_code, glyph_row[3:0]}
- `char_pixels`  in  8  font row, registered ROM: valid 1 cycle after the address; MSB is the leftmost pixel
- `hcount_out`, `vcount_out`, `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`, `rgb_out`  out  same widths as the inputs  delayed stream

## Operation
- Character cell is 8×16 px, grid is 16×16 cells, so the box is 128×256 px.
- `in_box` = (`XPOS` ≤ hcount < `XPOS`+128) && (`YPOS` ≤ vcount < `YPOS`+256).
  - Evaluated with unsigned compares, never by testing the sign of the subtraction.
  - `XPOS`+128 and `YPOS`+256 are computed at 12 bits, so a box at the right or bottom edge of the 11-bit range does not wrap.
- Relative offsets: rel_x = hcount − `XPOS`, rel_y = vcount − `YPOS`, both mod 2^11; only the low bits are used.
- `char_xy` = {rel_y[7:4], rel_x[6:3]} when `in_box`; otherwise 8'h00.
- `char_line_addr` = {char_code, rel_y[3:0]}.
- Glyph bit = `char_pixels`[7 − rel_x[2:0]].
- Output pixel selection:
  - Either output blanking flag is set: `rgb_out` = 12'h000.
  - Else `in_box` and the glyph bit is 1: `rgb_out` = `FG_COLOR`.
  - Else: `rgb_out` = `rgb_in` delayed (see Configuration).
- `char_code` values the ROM leaves undefined are not checked; the block renders whatever glyph the font returns.

## Timing
Pipeline, with t = the cycle the inputs are sampled:
- Edge t+1 (S1): register `char_xy`, rel_y[3:0], rel_x[2:0] and `in_box`.
- Edge t+2 (S2): register `char_line_addr` from `char_code`.
- Edge t+3: font ROM registers `char_pixels`. Side-band signals are delayed alongside it.
- Edge t+4 (S4): outputs registered.

Latency and throughput:
- Total latency is exactly 4 cycles for every output signal.
- Throughput is 1 pixel per clock; there are no stalls and no handshake.

Reset behaviour:
- While `rst`=0, every register and every output is 0. This includes `char_xy`=8'h00, `char_line_addr`=11'h000, all sync/blank outputs 0 and `rgb_out`=0.
- Reset asserted mid-frame clears the pipeline immediately (asynchronous).
- After release, outputs carry valid stream data from the 4th rising edge onward.

Boundaries:
- hcount = `XPOS`+127 is the last column inside the box; `XPOS`+128 is outside.
- vcount = `YPOS`+255 is the last row inside the box; `YPOS`+256 is outside.
- A box partly off-screen is legal; rows and columns outside the visible area are blanked.

## Configuration
Macro `TEXT_BG_EN` selects the fill for in-box pixels whose glyph bit is 0:
- Defined: such pixels output `BG_COLOR`, giving an opaque text box.
- Undefined: such pixels pass `rgb_in` (delayed) through, giving transparent text. `BG_COLOR` is unused.

Blanking and out-of-box behaviour are identical in both builds.

## Test plan
1. Hold `rst`=0 with random inputs → all outputs 0, `char_xy`=8'h00, `char_line_addr`=11'h000. Release `rst` → first valid output after 4 edges.
2. `XPOS`=100, `YPOS`=50. Drive hcount=100, vcount=50, `char_code`=7'h42 → after edge 1, `char_xy`=8'h00; after edge 2, `char_line_addr`=11'h420.
3. Drive hcount=129, vcount=89 (col 3, row 2, glyph row 7, bit 5) with `char_code`=7'h63 and `char_pixels`=8'b0000_0100 → `char_xy`=8'h23, `char_line_addr`=11'h637, and `rgb_out`=`FG_COLOR` 4 cycles after the input.
4. Drive hcount=99 (just left of the box) and hcount=228 (just right of the box), with `rgb_in`=12'hABC → `char_xy`=8'h00 and `rgb_out`=12'hABC after 4 cycles. The timing outputs equal the inputs delayed by 4 cycles.
5. Same pixel as scenario 3 with `hblnk_in`=1 → `rgb_out`=12'h000.
6. In-box pixel with glyph bit 0 and `rgb_in`=12'h123 → 12'h123 without `TEXT_BG_EN`; `BG_COLOR` with `TEXT_BG_EN` defined.
